// File: rtl/dispense_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : dispense_scheduler
// Purpose  : Queues snack orders and issues them one at a time to the
//            per-slot dispense controllers, with ack timeout and settle gap.
// Revision : 1.0 - initial release
// ============================================================================
module dispense_scheduler #(
    parameter int NUM_SLOTS   = 4,
    parameter int FIFO_DEPTH  = 4,
    parameter int ACK_TIMEOUT = 16,
    parameter int GAP_CLOCKS  = 5_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 order_valid,
    output logic                 order_ready,
    input  logic [1:0]           order_slot,
    input  logic [2:0]           order_count,
    output logic [NUM_SLOTS-1:0] start_dispense,
    output logic [2:0]           dispense_count_out,
    input  logic [NUM_SLOTS-1:0] busy_in,
    output logic                 done,
    output logic                 fault,
    output logic [1:0]           result_slot,
    output logic [3:0]           queue_level,
    output logic                 sched_busy
);

    localparam int c_PTR_W   = $clog2(FIFO_DEPTH);
    localparam int c_TMR_MAX = (GAP_CLOCKS > ACK_TIMEOUT) ? GAP_CLOCKS : ACK_TIMEOUT;
    localparam int c_TMR_W   = $clog2(c_TMR_MAX + 1);

    localparam logic [2:0]         c_NUM_SLOTS = 3'(NUM_SLOTS);
    localparam logic [3:0]         c_DEPTH     = 4'(FIFO_DEPTH);
    localparam logic [c_TMR_W-1:0] c_ACK_LAST  = c_TMR_W'(ACK_TIMEOUT - 1);
    localparam logic [c_TMR_W-1:0] c_GAP_LAST  = c_TMR_W'(GAP_CLOCKS - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_ACK  = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_GAP       = 3'd4
    } state_t;

    state_t                 r_state;
    logic [4:0]             r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]     r_wr_ptr;
    logic [c_PTR_W-1:0]     r_rd_ptr;
    logic [3:0]             r_count;
    logic [1:0]             r_active_slot;
    logic [2:0]             r_active_count;
    logic [NUM_SLOTS-1:0]   r_sel;
    logic [NUM_SLOTS-1:0]   r_start;
    logic [c_TMR_W-1:0]     r_timer;
    logic                   r_done;
    logic                   r_fault;
    logic [1:0]             r_result_slot;

    logic                   w_full;
    logic                   w_push;
    logic                   w_pop;
    logic [1:0]             w_head_slot;
    logic [2:0]             w_head_count;
    logic [NUM_SLOTS-1:0]   w_onehot;
    logic                   w_ack;

    assign w_full       = (r_count == c_DEPTH);
    assign order_ready  = !rst && !w_full;
    assign w_push       = order_valid && order_ready;
    assign w_pop        = (r_state == ST_IDLE) && (r_count != 4'd0);
    assign w_head_slot  = r_mem[r_rd_ptr][4:3];
    assign w_head_count = r_mem[r_rd_ptr][2:0];
    assign w_onehot     = NUM_SLOTS'(1) << w_head_slot;
    // Only the selected controller's busy flag matters.
    assign w_ack        = |(busy_in & r_sel);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= 4'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {order_slot, order_count};
                r_wr_ptr        <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 4'd1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_active_slot  <= 2'd0;
            r_active_count <= 3'd0;
            r_sel          <= '0;
            r_start        <= '0;
            r_timer        <= '0;
            r_done         <= 1'b0;
            r_fault        <= 1'b0;
            r_result_slot  <= 2'd0;
        end else begin
            r_start <= '0;
            r_done  <= 1'b0;
            r_fault <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_active_slot <= w_head_slot;
                        if (w_head_count == 3'd0) begin
                            r_state <= ST_IDLE;
                        end else if ({1'b0, w_head_slot} >= c_NUM_SLOTS) begin
                            r_fault       <= 1'b1;
                            r_result_slot <= w_head_slot;
                        end else begin
                            // Start pulse is registered so it lines up with ISSUE.
                            r_active_count <= w_head_count;
                            r_sel          <= w_onehot;
                            r_start        <= w_onehot;
                            r_state        <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    r_timer <= '0;
                    r_state <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (w_ack) begin
                        r_state <= ST_WAIT_DONE;
                    end else if (r_timer == c_ACK_LAST) begin
                        r_fault       <= 1'b1;
                        r_result_slot <= r_active_slot;
                        r_timer       <= '0;
                        r_state       <= ST_GAP;
                    end else begin
                        r_timer <= r_timer + c_TMR_W'(1);
                    end
                end
                ST_WAIT_DONE: begin
                    if (!w_ack) begin
                        r_done        <= 1'b1;
                        r_result_slot <= r_active_slot;
                        r_timer       <= '0;
                        r_state       <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (r_timer == c_GAP_LAST) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_timer <= r_timer + c_TMR_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign start_dispense     = r_start;
    assign dispense_count_out = r_active_count;
    assign done               = r_done;
    assign fault              = r_fault;
    assign result_slot        = r_result_slot;
    assign queue_level        = r_count;
    assign sched_busy         = (r_state != ST_IDLE) || (r_count != 4'd0);

endmodule
`default_nettype wire

// File: tb/tb_dispense_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_dispense_scheduler
// Purpose  : Directed self-checking bench for dispense_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dispense_scheduler;

    localparam int c_DUR = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    always #5 clk = ~clk;

    logic       order_valid = 1'b0;
    logic       order_ready;
    logic [1:0] order_slot  = 2'd0;
    logic [2:0] order_count = 3'd0;
    logic [3:0] start_dispense;
    logic [2:0] dispense_count_out;
    logic [3:0] busy_in;
    logic       done;
    logic       fault;
    logic [1:0] result_slot;
    logic [3:0] queue_level;
    logic       sched_busy;

    logic       v3 = 1'b0;
    logic       ready3;
    logic [1:0] s3 = 2'd0;
    logic [2:0] c3 = 3'd0;
    logic [2:0] start3;
    logic [2:0] cnt3_out;
    logic [2:0] busy3 = 3'b000;
    logic       done3;
    logic       fault3;
    logic [1:0] res3;
    logic [3:0] q3;
    logic       sb3;

    dispense_scheduler #(
        .NUM_SLOTS(4), .FIFO_DEPTH(4), .ACK_TIMEOUT(16), .GAP_CLOCKS(5)
    ) u_dut (
        .clk(clk), .rst(rst),
        .order_valid(order_valid), .order_ready(order_ready),
        .order_slot(order_slot), .order_count(order_count),
        .start_dispense(start_dispense), .dispense_count_out(dispense_count_out),
        .busy_in(busy_in), .done(done), .fault(fault),
        .result_slot(result_slot), .queue_level(queue_level), .sched_busy(sched_busy)
    );

    dispense_scheduler #(
        .NUM_SLOTS(3), .FIFO_DEPTH(4), .ACK_TIMEOUT(16), .GAP_CLOCKS(5)
    ) u_dut3 (
        .clk(clk), .rst(rst),
        .order_valid(v3), .order_ready(ready3),
        .order_slot(s3), .order_count(c3),
        .start_dispense(start3), .dispense_count_out(cnt3_out),
        .busy_in(busy3), .done(done3), .fault(fault3),
        .result_slot(res3), .queue_level(q3), .sched_busy(sb3)
    );

    // Downstream controller model: busy rises the cycle after start, for c_DUR cycles.
    int         bcnt [4];
    logic [3:0] en = 4'hF;
    always @(posedge clk) begin
        for (int s = 0; s < 4; s++) begin
            if (start_dispense[s] && en[s]) bcnt[s] <= c_DUR;
            else if (bcnt[s] != 0)          bcnt[s] <= bcnt[s] - 1;
        end
    end
    always_comb begin
        busy_in = 4'b0000;
        for (int s = 0; s < 4; s++) busy_in[s] = (bcnt[s] != 0);
    end

    int n_cmp = 0;
    int n_err = 0;
    int n_done = 0, n_fault = 0, n_start = 0, n_overlap = 0, n_start3 = 0, n_fault3 = 0;
    int q_slot[$];
    int q_cnt[$];

    always @(negedge clk) begin
        if (start_dispense != 4'b0000) begin
            n_start <= n_start + 1;
            for (int s = 0; s < 4; s++) if (start_dispense[s]) q_slot.push_back(s);
            q_cnt.push_back(int'(dispense_count_out));
        end
        if (done)                   n_done    <= n_done + 1;
        if (fault)                  n_fault   <= n_fault + 1;
        if ($countones(busy_in) > 1) n_overlap <= n_overlap + 1;
        if (start3 != 3'b000)       n_start3  <= n_start3 + 1;
        if (fault3)                 n_fault3  <= n_fault3 + 1;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int slot, input int cnt);
        int n;
        n = 0;
        order_valid = 1'b1;
        order_slot  = 2'(slot);
        order_count = 3'(cnt);
        while (!order_ready && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) chk("push_ready_timeout", 0, 1);
        tick();
        order_valid = 1'b0;
    endtask

    function automatic logic cond(input int w);
        case (w)
            0:       return done;
            1:       return fault;
            2:       return start_dispense != 4'b0000;
            default: return !sched_busy;
        endcase
    endfunction

    task automatic wait_for(input int w, input int max, output int n);
        n = 0;
        while (!cond(w) && n < max) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int snap_done, snap_start;
        int exp_s[$];
        int exp_c[$];

        // Reset values
        tick();
        tick();
        chk("rst_ready", order_ready, 0);
        chk("rst_qlevel", queue_level, 0);
        chk("rst_start", start_dispense, 0);
        chk("rst_done_fault", {done, fault}, 0);
        chk("rst_result", result_slot, 0);
        chk("rst_cntout", dispense_count_out, 0);
        chk("rst_sbusy", sched_busy, 0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", order_ready, 1);

        // Single order, best-case latency
        push(2, 3);
        chk("t1_start_early", start_dispense, 0);
        chk("t1_qlevel", queue_level, 1);
        tick();
        chk("t1_start", start_dispense, 4'b0100);
        chk("t1_cntout", dispense_count_out, 3);
        wait_for(0, 40, n);
        chk("t1_done_lat", n, 12);
        chk("t1_result", result_slot, 2);
        chk("t1_nofault", fault, 0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (i == 4) chk("t1_sbusy_gap", sched_busy, 1);
            if (i == 5) chk("t1_sbusy_fall", sched_busy, 0);
        end

        // Five back-to-back orders into a 4-deep queue
        q_slot.delete();
        q_cnt.delete();
        exp_s = '{0, 1, 2, 3, 1};
        exp_c = '{1, 2, 1, 2, 1};
        for (int i = 0; i < 5; i++) push(exp_s[i], exp_c[i]);
        chk("t2_qlevel_peak", queue_level, 4);
        chk("t2_ready_low", order_ready, 0);
        wait_for(3, 400, n);
        chk("t2_idle", sched_busy, 0);
        chk("t2_n_issued", q_slot.size(), 5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t2_ord%0d_slot", i), q_slot[i], exp_s[i]);
            chk($sformatf("t2_ord%0d_cnt", i), q_cnt[i], exp_c[i]);
        end

        // Ack timeout on slot 1, followed by a normal order
        snap_done = n_done;
        en[1] = 1'b0;
        push(1, 2);
        push(0, 1);
        chk("t3_start", start_dispense, 4'b0010);
        wait_for(1, 40, n);
        chk("t3_fault_lat", n, 17);
        chk("t3_result", result_slot, 1);
        chk("t3_no_done", n_done, snap_done);
        en[1] = 1'b1;
        wait_for(2, 40, n);
        chk("t3_next_lat", n, 6);
        chk("t3_next_start", start_dispense, 4'b0001);
        wait_for(3, 100, n);
        chk("t3_idle", sched_busy, 0);
        chk("t3_done_cnt", n_done, snap_done + 1);

        // Zero-count drop and invalid slot on the 3-slot instance
        v3 = 1'b1; s3 = 2'd0; c3 = 3'd0;
        tick();
        s3 = 2'd3; c3 = 3'd1;
        tick();
        v3 = 1'b0;
        chk("t4_q_mid", q3, 1);
        chk("t4_nofault_zero", fault3, 0);
        tick();
        chk("t4_fault", fault3, 1);
        chk("t4_result", res3, 3);
        chk("t4_drained", q3, 0);
        chk("t4_sbusy", sb3, 0);
        for (int i = 0; i < 10; i++) tick();
        chk("t4_nstart", n_start3, 0);
        chk("t4_nfault", n_fault3, 1);

        // Reset during WAIT_DONE with two orders queued
        push(2, 1);
        push(0, 1);
        push(1, 1);
        chk("t5_qlevel", queue_level, 2);
        tick();
        snap_done  = n_done;
        snap_start = n_start;
        rst = 1'b1;
        tick();
        chk("t5_rst_qlevel", queue_level, 0);
        chk("t5_rst_start", start_dispense, 0);
        chk("t5_rst_done_fault", {done, fault}, 0);
        chk("t5_rst_result", result_slot, 0);
        chk("t5_rst_cntout", dispense_count_out, 0);
        chk("t5_rst_sbusy", sched_busy, 0);
        chk("t5_rst_ready", order_ready, 0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("t5_no_done", n_done, snap_done);
        chk("t5_no_start", n_start, snap_start);
        chk("t5_still_idle", sched_busy, 0);

        // Push coinciding with a pop while two are queued
        q_slot.delete();
        q_cnt.delete();
        push(3, 1);
        push(0, 2);
        push(1, 3);
        for (int i = 0; i < 16; i++) tick();
        chk("t6_q_before", queue_level, 2);
        order_valid = 1'b1; order_slot = 2'd2; order_count = 3'd1;
        tick();
        order_valid = 1'b0;
        chk("t6_q_after", queue_level, 2);
        chk("t6_start_a", start_dispense, 4'b0001);
        wait_for(3, 300, n);
        chk("t6_idle", sched_busy, 0);
        exp_s = '{3, 0, 1, 2};
        exp_c = '{1, 2, 3, 1};
        chk("t6_n_issued", q_slot.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t6_ord%0d_slot", i), q_slot[i], exp_s[i]);
            chk($sformatf("t6_ord%0d_cnt", i), q_cnt[i], exp_c[i]);
        end

        chk("busy_overlap", n_overlap, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
